// File: rtl/mr_alloc.sv
// Rotating-priority allocator: matches pending requesters onto free interchangeable
// resources; a grant and its resource are held until the requester drops req.
module mr_alloc #(
  parameter int NREQ = 4,
  parameter int NRES = 4,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NRES-1:0]      res_en,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ*NRES-1:0] gmap,
  output logic [NRES-1:0]      busy,
  output logic [PW-1:0]        rr_ptr
);

  logic [NREQ-1:0]      r_gnt;
  logic [NREQ*NRES-1:0] r_gmap;
  logic [NRES-1:0]      r_busy;
  logic [PW-1:0]        r_ptr;

  logic [NREQ-1:0]      w_hold;
  logic [NREQ-1:0]      w_pending;
  logic [NRES-1:0]      w_free;
  logic [NREQ-1:0]      w_new_gnt;
  logic [NREQ*NRES-1:0] w_new_map;
  logic [NREQ*NRES-1:0] w_map_nxt;
  logic [NRES-1:0]      w_busy_nxt;
  logic [PW-1:0]        w_ptr_nxt;

  assign w_hold    = r_gnt & req;
  assign w_pending = req & ~r_gnt;
  // Uses registered busy, so a resource released this edge is only offered next edge.
  assign w_free    = res_en & ~r_busy;

  always_comb begin : alloc
    int unsigned idx;
    logic [NRES-1:0] rem;
    logic [NRES-1:0] pick;
    w_new_gnt = '0;
    w_new_map = '0;
    w_ptr_nxt = r_ptr;
    rem       = w_free;
    pick      = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (w_pending[idx] && (rem != '0)) begin
        // Isolate the lowest-index remaining free resource.
        pick = rem & (~rem + NRES'(1));
        rem  = rem & ~pick;
        w_new_gnt[idx]               = 1'b1;
        w_new_map[idx*NRES +: NRES]  = pick;
        w_ptr_nxt = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_comb begin : next_map
    w_map_nxt  = w_new_map;
    w_busy_nxt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_hold[i]) w_map_nxt[i*NRES +: NRES] = r_gmap[i*NRES +: NRES];
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_busy_nxt = w_busy_nxt | w_map_nxt[i*NRES +: NRES];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt  <= '0;
      r_gmap <= '0;
      r_busy <= '0;
      r_ptr  <= '0;
    end else begin
      r_gnt  <= w_hold | w_new_gnt;
      r_gmap <= w_map_nxt;
      r_busy <= w_busy_nxt;
      r_ptr  <= w_ptr_nxt;
    end
  end

  assign gnt    = r_gnt;
  assign gmap   = r_gmap;
  assign busy   = r_busy;
  assign rr_ptr = r_ptr;

endmodule

// File: tb/tb_mr_alloc.sv
// Bench for mr_alloc: directed scenarios with fixed expectations, then randomized
// traffic against an ownership-table reference model plus invariant and starvation checks.
module tb_mr_alloc;
  localparam int NREQ = 4;
  localparam int NRES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  res_en;
  logic [3:0]  gnt;
  logic [15:0] gmap;
  logic [3:0]  busy;
  logic [1:0]  rr_ptr;

  int total = 0;
  int bad   = 0;

  int m_own[NREQ];
  int m_ptr;
  logic [3:0]  e_gnt;
  logic [15:0] e_gmap;
  logic [3:0]  e_busy;
  logic [1:0]  e_ptr;

  mr_alloc #(.NREQ(NREQ), .NRES(NRES)) dut (
    .clk(clk), .rst(rst), .req(req), .res_en(res_en),
    .gnt(gnt), .gmap(gmap), .busy(busy), .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic model_out();
    e_gnt = '0; e_gmap = '0; e_busy = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (m_own[i] >= 0) begin
        e_gnt[i] = 1'b1;
        e_gmap[i*NRES + m_own[i]] = 1'b1;
        e_busy[m_own[i]] = 1'b1;
      end
    end
    e_ptr = 2'(m_ptr);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) m_own[i] = -1;
    m_ptr = 0;
    model_out();
  endtask

  // Ownership table: m_own[i] is the resource held by requester i, or -1.
  task automatic model_edge(input logic [3:0] rq, input logic [3:0] en);
    int nown[NREQ];
    bit taken[NRES];
    int freeq[$];
    int last;
    int i;
    last = -1;
    for (int r = 0; r < NRES; r++) taken[r] = 0;
    for (int j = 0; j < NREQ; j++) begin
      nown[j] = m_own[j];
      if (m_own[j] >= 0) taken[m_own[j]] = 1;
      if (m_own[j] >= 0 && !rq[j]) nown[j] = -1;
    end
    for (int r = 0; r < NRES; r++) if (en[r] && !taken[r]) freeq.push_back(r);
    for (int k = 0; k < NREQ; k++) begin
      i = (m_ptr + k) % NREQ;
      if (rq[i] && m_own[i] < 0 && freeq.size() > 0) begin
        nown[i] = freeq.pop_front();
        last = i;
      end
    end
    m_own = nown;
    if (last >= 0) m_ptr = (last + 1) % NREQ;
    model_out();
  endtask

  task automatic step(input logic [3:0] rq, input logic [3:0] en);
    req = rq; res_en = en;
    @(posedge clk);
    model_edge(rq, en);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; res_en = '0;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; res_en = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0); end
    total++; if (gmap !== 16'h0) begin bad++; $display("FAIL reset_gmap got=%h exp=%h", gmap, 16'h0); end
    total++; if (busy !== 4'b0) begin bad++; $display("FAIL reset_busy got=%b exp=%b", busy, 4'b0); end
    total++; if (rr_ptr !== 2'd0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", rr_ptr); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    step(4'b0001, 4'b1111);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
    total++; if (gmap !== 16'h0001) begin bad++; $display("FAIL single_gmap got=%h exp=0001", gmap); end
    total++; if (busy !== 4'b0001) begin bad++; $display("FAIL single_busy got=%b exp=0001", busy); end
    total++; if (rr_ptr !== 2'd1) begin bad++; $display("FAIL single_ptr got=%0d exp=1", rr_ptr); end
    step(4'b0000, 4'b1111);
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_rel_gnt got=%b exp=0000", gnt); end
    total++; if (busy !== 4'b0000) begin bad++; $display("FAIL single_rel_busy got=%b exp=0000", busy); end
    total++; if (rr_ptr !== 2'd1) begin bad++; $display("FAIL single_rel_ptr got=%0d exp=1", rr_ptr); end
  endtask

  task automatic test_multi();
    do_reset();
    step(4'b1111, 4'b0011);
    total++; if (gnt !== 4'b0011) begin bad++; $display("FAIL multi_gnt got=%b exp=0011", gnt); end
    total++; if (gmap !== 16'h0021) begin bad++; $display("FAIL multi_gmap got=%h exp=0021", gmap); end
    total++; if (rr_ptr !== 2'd2) begin bad++; $display("FAIL multi_ptr got=%0d exp=2", rr_ptr); end
    step(4'b1110, 4'b0011);
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL multi_rel_gnt got=%b exp=0010", gnt); end
    total++; if (busy !== 4'b0010) begin bad++; $display("FAIL multi_rel_busy got=%b exp=0010", busy); end
    total++; if (gmap !== 16'h0020) begin bad++; $display("FAIL multi_rel_gmap got=%h exp=0020", gmap); end
    step(4'b1110, 4'b0011);
    total++; if (gnt !== 4'b0110) begin bad++; $display("FAIL multi_next_gnt got=%b exp=0110", gnt); end
    total++; if (gmap !== 16'h0120) begin bad++; $display("FAIL multi_next_gmap got=%h exp=0120", gmap); end
    total++; if (busy !== 4'b0011) begin bad++; $display("FAIL multi_next_busy got=%b exp=0011", busy); end
    total++; if (rr_ptr !== 2'd3) begin bad++; $display("FAIL multi_next_ptr got=%0d exp=3", rr_ptr); end
  endtask

  // Single enabled resource: grants must rotate 0,1,2,3,0.
  task automatic test_fairness();
    logic [3:0] expg;
    do_reset();
    for (int g = 0; g < 5; g++) begin
      expg = 4'b0001 << (g % 4);
      step(4'b1111, 4'b0001);
      total++; if (gnt !== expg) begin bad++; $display("FAIL fair_gnt%0d got=%b exp=%b", g, gnt, expg); end
      total++; if (busy !== 4'b0001) begin bad++; $display("FAIL fair_busy%0d got=%b exp=0001", g, busy); end
      total++; if (rr_ptr !== 2'((g + 1) % 4)) begin bad++; $display("FAIL fair_ptr%0d got=%0d exp=%0d", g, rr_ptr, (g + 1) % 4); end
      step(4'b1111 & ~expg, 4'b0001);
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL fair_rel%0d got=%b exp=0000", g, gnt); end
    end
  endtask

  task automatic test_res_en_hold();
    do_reset();
    step(4'b0001, 4'b1111);
    step(4'b0001, 4'b1110);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL hold_gnt got=%b exp=0001", gnt); end
    total++; if (gmap !== 16'h0001) begin bad++; $display("FAIL hold_gmap got=%h exp=0001", gmap); end
    step(4'b0000, 4'b1110);
    total++; if (busy !== 4'b0000) begin bad++; $display("FAIL hold_rel_busy got=%b exp=0000", busy); end
    step(4'b1111, 4'b1110);
    total++; if (gnt !== 4'b1110) begin bad++; $display("FAIL hold_fill_gnt got=%b exp=1110", gnt); end
    total++; if (gmap !== 16'h8420) begin bad++; $display("FAIL hold_fill_gmap got=%h exp=8420", gmap); end
    total++; if (rr_ptr !== 2'd0) begin bad++; $display("FAIL hold_fill_ptr got=%0d exp=0", rr_ptr); end
    for (int c = 0; c < 3; c++) begin
      step(4'b1111, 4'b1110);
      total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL hold_dis%0d got=%b exp=0", c, busy[0]); end
    end
    step(4'b1111, 4'b1111);
    total++; if (gnt !== 4'b1111) begin bad++; $display("FAIL hold_en_gnt got=%b exp=1111", gnt); end
    total++; if (gmap !== 16'h8421) begin bad++; $display("FAIL hold_en_gmap got=%h exp=8421", gmap); end
    total++; if (rr_ptr !== 2'd1) begin bad++; $display("FAIL hold_en_ptr got=%0d exp=1", rr_ptr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(4'b1111, 4'b1111);
    total++; if (gnt !== 4'b1111) begin bad++; $display("FAIL arst_pre_gnt got=%b exp=1111", gnt); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (gnt !== 4'b0) begin bad++; $display("FAIL arst_gnt got=%b exp=0000", gnt); end
    total++; if (gmap !== 16'h0) begin bad++; $display("FAIL arst_gmap got=%h exp=0000", gmap); end
    total++; if (busy !== 4'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0000", busy); end
    total++; if (rr_ptr !== 2'd0) begin bad++; $display("FAIL arst_ptr got=%0d exp=0", rr_ptr); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(4'b1111, 4'b0001);
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL arst_restart_gnt got=%b exp=0001", gnt); end
    total++; if (rr_ptr !== 2'd1) begin bad++; $display("FAIL arst_restart_ptr got=%0d exp=1", rr_ptr); end
  endtask

  task automatic test_random();
    logic [3:0] cur, en, prevg, acc, row;
    int wt[NREQ];
    int rels;
    bit phb;
    do_reset();
    cur = '0;
    for (int i = 0; i < NREQ; i++) wt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      phb = (c >= 7000);
      if (c == 7000) begin
        do_reset();
        cur = '0;
        for (int i = 0; i < NREQ; i++) wt[i] = 0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!cur[i]) begin
          if ($urandom_range(0, 2) == 0) cur[i] = 1'b1;
        end else if (e_gnt[i]) begin
          if ($urandom_range(0, 3) == 0) cur[i] = 1'b0;
        end else if (!phb && $urandom_range(0, 31) == 0) begin
          cur[i] = 1'b0;
        end
      end
      en = phb ? 4'b0011 : 4'($urandom() | $urandom());
      prevg = gnt;
      rels = $countones(prevg & ~cur);
      step(cur, en);
      total++; if (gnt !== e_gnt) begin bad++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, gnt, e_gnt); end
      total++; if (gmap !== e_gmap) begin bad++; $display("FAIL rnd_gmap c=%0d got=%h exp=%h", c, gmap, e_gmap); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, e_busy); end
      total++; if (rr_ptr !== e_ptr) begin bad++; $display("FAIL rnd_ptr c=%0d got=%0d exp=%0d", c, rr_ptr, e_ptr); end
      acc = '0;
      for (int i = 0; i < NREQ; i++) begin
        row = gmap[i*NRES +: NRES];
        total++;
        if ($countones(row) > 1 || ((row != '0) != gnt[i])) begin
          bad++; $display("FAIL inv_row c=%0d row%0d got=%b gnt=%b exp=onehot_iff_gnt", c, i, row, gnt[i]);
        end
        total++;
        if ((acc & row) != '0) begin
          bad++; $display("FAIL inv_overlap c=%0d row%0d got=%b exp=disjoint_from=%b", c, i, row, acc);
        end
        acc = acc | row;
      end
      total++; if (busy !== acc) begin bad++; $display("FAIL inv_busy c=%0d got=%b exp=%b", c, busy, acc); end
      if (phb) begin
        for (int i = 0; i < NREQ; i++) begin
          if (cur[i] && !prevg[i]) begin
            if (gnt[i]) begin
              total++;
              if (wt[i] > NREQ) begin bad++; $display("FAIL starve c=%0d req%0d got=%0d exp<=%0d", c, i, wt[i], NREQ); end
              wt[i] = 0;
            end else begin
              wt[i] += rels;
              if (wt[i] > NREQ) begin
                total++; bad++;
                $display("FAIL starve_wait c=%0d req%0d got=%0d exp<=%0d", c, i, wt[i], NREQ);
                wt[i] = 0;
              end
            end
          end else begin
            wt[i] = 0;
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; res_en = '0;
    test_reset();
    test_single();
    test_multi();
    test_fairness();
    test_res_en_hold();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
